// File: rtl/four_bit_parallel_sub.sv
// rtl/four_bit_parallel_sub.sv - 4-bit ripple subtractor with registered result, carries and valid
//
// Purpose:
//   Computes {cout, s} = a + ~b + cin through four chained full-adder stages.
//   The difference, the three internal stage carries and the final carry are
//   captured together in one set of output registers whenever in_valid is high.
//   With cin = 1 the result is the two's-complement difference a - b, and
//   cout = 1 means no borrow occurred.
//
// Ports:
//   clk        in   1  rising-edge clock
//   rst_n      in   1  asynchronous active-low reset
//   in_valid   in   1  sample a, b, cin at this edge
//   a          in   4  minuend
//   b          in   4  subtrahend (inverted inside the block)
//   cin        in   1  carry into bit 0
//   s          out  4  registered difference bits
//   c          out  3  registered carries into stages 3..1
//   cout       out  1  registered carry out of stage 3
//   out_valid  out  1  high for the cycle after a sampled input

module four_bit_parallel_sub (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic [3:1] c,
  output logic       cout,
  output logic       out_valid
);

  logic [3:0] w_bn;
  logic [4:0] w_k;
  logic [3:0] w_sum;

  logic [3:0] r_s;
  logic [3:1] r_c;
  logic       r_cout;
  logic       r_out_valid;

  assign w_bn = ~b;

  // Ripple chain: w_k[i] is the carry into stage i, w_k[0] is the external carry-in.
  always_comb begin
    w_k      = '0;
    w_sum    = '0;
    w_k[0]   = cin;
    for (int i = 0; i < 4; i++) begin
      w_sum[i] = a[i] ^ w_bn[i] ^ w_k[i];
      w_k[i+1] = (a[i] & w_bn[i]) | (a[i] & w_k[i]) | (w_bn[i] & w_k[i]);
    end
  end

  // Data registers only load on a valid sample; the valid flag tracks every edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s         <= '0;
      r_c         <= '0;
      r_cout      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_s    <= w_sum;
        r_c    <= w_k[3:1];
        r_cout <= w_k[4];
      end
    end
  end

  assign s         = r_s;
  assign c         = r_c;
  assign cout      = r_cout;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_four_bit_parallel_sub.sv
// tb/tb_four_bit_parallel_sub.sv - self-checking bench for four_bit_parallel_sub

module tb_four_bit_parallel_sub;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic [3:0] s;
  logic [3:1] c;
  logic       cout;
  logic       out_valid;

  int n_tests;
  int n_fail;

  // Reference state: what the outputs should currently show.
  logic [3:0] m_s;
  logic [2:0] m_c;
  logic       m_cout;
  logic       m_ov;

  four_bit_parallel_sub dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .s         (s),
    .c         (c),
    .cout      (cout),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Carry into stage i equals bit i of the sum of the low i bits of each operand plus cin.
  task automatic model(input int ai, input int bi, input int ci,
                       output logic [3:0] es, output logic [2:0] ec, output logic ecout);
    int bn;
    int full;
    int mask;
    int part;
    bn    = 15 - bi;
    full  = ai + bn + ci;
    es    = full[3:0];
    ecout = full[4];
    for (int i = 1; i <= 3; i++) begin
      mask      = (1 << i) - 1;
      part      = (ai & mask) + (bn & mask) + ci;
      ec[i-1]   = part[i];
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".s"},    32'(s),         32'(m_s));
    check({tag, ".c"},    32'(c),         32'(m_c));
    check({tag, ".cout"}, 32'(cout),      32'(m_cout));
    check({tag, ".ov"},   32'(out_valid), 32'(m_ov));
  endtask

  task automatic step(input string tag, input logic v, input int ai, input int bi, input int ci);
    logic [3:0] es;
    logic [2:0] ec;
    logic       eco;
    @(negedge clk);
    in_valid = v;
    a        = 4'(ai);
    b        = 4'(bi);
    cin      = ci[0];
    @(posedge clk);
    #1;
    if (v) begin
      model(ai, bi, ci, es, ec, eco);
      m_s    = es;
      m_c    = ec;
      m_cout = eco;
    end
    m_ov = v;
    check_outputs(tag);
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
    m_s = '0; m_c = '0; m_cout = 1'b0; m_ov = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors, also checked against hand-derived constants.
    step("d5m3", 1'b1, 5, 3, 1);
    check("d5m3.s_const", 32'(s), 32'h2);
    check("d5m3.c_const", 32'(c), 32'h5);
    check("d5m3.co_const", 32'(cout), 32'h1);
    step("d3m5", 1'b1, 3, 5, 1);
    check("d3m5.s_const", 32'(s), 32'hE);
    check("d3m5.c_const", 32'(c), 32'h3);
    check("d3m5.co_const", 32'(cout), 32'h0);
    step("d00c0", 1'b1, 0, 0, 0);
    check("d00c0.s_const", 32'(s), 32'hF);
    check("d00c0.c_const", 32'(c), 32'h0);
    step("d00c1", 1'b1, 0, 0, 1);
    check("d00c1.s_const", 32'(s), 32'h0);
    check("d00c1.c_const", 32'(c), 32'h7);
    check("d00c1.co_const", 32'(cout), 32'h1);
    step("dF0", 1'b1, 15, 0, 1);
    check("dF0.s_const", 32'(s), 32'hF);
    check("dF0.c_const", 32'(c), 32'h7);
    step("hold1", 1'b0, 2, 9, 0);
    step("hold2", 1'b0, 7, 1, 1);
    check("hold2.s_const", 32'(s), 32'hF);
    check("hold2.ov_const", 32'(out_valid), 32'h0);

    // Asynchronous reset between edges with nonzero outputs and a live input.
    step("pre_rst", 1'b1, 9, 2, 1);
    @(negedge clk);
    in_valid = 1'b1;
    a = 4'hA; b = 4'h1; cin = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    m_s = '0; m_c = '0; m_cout = 1'b0; m_ov = 1'b0;
    check_outputs("async_rst");
    @(posedge clk);
    #1;
    check_outputs("rst_held");
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    step("post_rst_idle", 1'b0, 4, 4, 1);
    step("post_rst_first", 1'b1, 12, 5, 1);

    // Exhaustive back-to-back sweep.
    for (int ci = 0; ci < 2; ci++)
      for (int ai = 0; ai < 16; ai++)
        for (int bi = 0; bi < 16; bi++)
          step("sweep", 1'b1, ai, bi, ci);

    // Randomized mix of valid and idle cycles.
    for (int n = 0; n < 300; n++)
      step("rand", 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 15)), int'($urandom_range(0, 1)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
